lcd_bus_writer: RTL and testbench

Downstream consumer of the LCD boot-sequence ROM. Accepts one command/data byte per valid/ready handshake and drives the HD44780-style 8-bit parallel bus (RS, RW, E, DB[7:0]) with the setup, enable-pulse, hold and execution-wait timing the controller requires. Once `in_ready` returns high, the address counter / ROM pair may present the next byte. Clear and return-home commands automatically get the long execution wait.

---
 rtl/lcd_bus_writer_if.sv | 32 +++
 rtl/lcd_bus_writer.sv | 134 +++++++++++++
 tb/tb_lcd_bus_writer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_writer_if.sv
// rtl/lcd_bus_writer_if.sv - byte handshake and HD44780 bus signals for lcd_bus_writer
//
// Purpose: groups the upstream valid/ready byte stream and the LCD parallel bus.
// Signals:
//   in_valid / in_ready  byte handshake (accept = in_valid && in_ready at a rising edge)
//   in_rs, in_data       register select and byte offered by the ROM stage
//   lcd_rs, lcd_rw,
//   lcd_e, lcd_db        HD44780-style 8-bit parallel bus
//   busy, done           transfer in progress / one-cycle completion pulse
// Modports: slave = the bus writer, master = the upstream stage / observer.
interface lcd_bus_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;
  logic       busy;
  logic       done;

  modport slave (
    input  in_valid, in_rs, in_data,
    output in_ready, lcd_rs, lcd_rw, lcd_e, lcd_db, busy, done
  );

  modport master (
    output in_valid, in_rs, in_data,
    input  in_ready, lcd_rs, lcd_rw, lcd_e, lcd_db, busy, done
  );
endinterface

// File: rtl/lcd_bus_writer.sv
// rtl/lcd_bus_writer.sv - HD44780 8-bit bus writer with setup/pulse/hold/exec-wait timing
//
// Purpose: accepts one byte per handshake and plays it onto the LCD bus as
// SETUP -> PULSE (E high) -> HOLD -> WAIT, then returns to IDLE.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    lcd_bus_writer_if.slave (handshake inputs, LCD bus and status outputs)
module lcd_bus_writer #(
  parameter int SETUP_CYC     = 2,
  parameter int PULSE_CYC     = 12,
  parameter int HOLD_CYC      = 2,
  parameter int WAIT_CYC      = 2000,
  parameter int LONG_WAIT_CYC = 82000
) (
  input logic               clk,
  input logic               rst_n,
  lcd_bus_writer_if.slave   bus
);

  localparam int CW = $clog2(LONG_WAIT_CYC + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  // Counter reload values: each state lasts (load + 1) cycles.
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] WAIT_LD  = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(LONG_WAIT_CYC - 1);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_rs;
  logic [7:0]    r_db;
  logic          r_long;
  logic          r_e;
  logic          r_done;
  logic          w_accept;
  logic          w_long;
  logic          w_cnt_zero;

  assign w_accept   = bus.in_valid && (r_state == S_IDLE);
  assign w_cnt_zero = (r_cnt == '0);
  // Clear (0x01) and return-home (0x02/0x03) instructions need the long execution wait.
  assign w_long     = !bus.in_rs && (bus.in_data[7:2] == 6'd0) && (bus.in_data != 8'd0);

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next     = S_SETUP;
          w_cnt_next = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_next     = S_PULSE;
          w_cnt_next = PULSE_LD;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      S_PULSE: begin
        if (w_cnt_zero) begin
          w_next     = S_HOLD;
          w_cnt_next = HOLD_LD;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      S_HOLD: begin
        if (w_cnt_zero) begin
          w_next     = S_WAIT;
          w_cnt_next = r_long ? LONG_LD : WAIT_LD;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      S_WAIT: begin
        if (w_cnt_zero) begin
          w_next     = S_IDLE;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rs    <= 1'b0;
      r_db    <= 8'h00;
      r_long  <= 1'b0;
      r_e     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      // E is a flop decoded from the next state so it never glitches.
      r_e     <= (w_next == S_PULSE);
      r_done  <= (r_state == S_WAIT) && w_cnt_zero;
      if (w_accept) begin
        r_rs   <= bus.in_rs;
        r_db   <= bus.in_data;
        r_long <= w_long;
      end
    end
  end

  assign bus.in_ready = (r_state == S_IDLE);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.lcd_rs   = r_rs;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_e    = r_e;
  assign bus.lcd_db   = r_db;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb/tb_lcd_bus_writer.sv - self-checking bench for lcd_bus_writer
module tb_lcd_bus_writer;
  localparam int S  = 2;
  localparam int P  = 4;
  localparam int H  = 2;
  localparam int W  = 10;
  localparam int LW = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_bus_writer_if bus();

  lcd_bus_writer #(
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .WAIT_CYC(W), .LONG_WAIT_CYC(LW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: time since the last accepted byte plus the latched byte.
  bit         m_active;
  int         m_d;
  int         m_w;
  logic       m_rs;
  logic [7:0] m_db;

  int         edge_n;
  int         acc_edge;
  int         done_lat;
  logic       prev_e;
  int         rise_edge[$];
  logic [7:0] rise_db[$];
  logic [7:0] stream [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  function automatic int m_total();
    return S + P + H + m_w;
  endfunction

  function automatic bit m_ready();
    return !m_active || (m_d >= m_total());
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 32'(bus.in_ready), 32'(m_ready()));
    chk("busy",     32'(bus.busy),     32'(!m_ready()));
    chk("lcd_e",    32'(bus.lcd_e),    32'(m_active && (m_d >= S) && (m_d < S + P)));
    chk("lcd_rs",   32'(bus.lcd_rs),   32'(m_rs));
    chk("lcd_db",   32'(bus.lcd_db),   32'(m_db));
    chk("lcd_rw",   32'(bus.lcd_rw),   32'(1'b0));
    chk("done",     32'(bus.done),     32'(m_active && (m_d == m_total())));
    if (bus.done === 1'b1) done_lat = edge_n - acc_edge + 1;
    if (bus.lcd_e === 1'b1 && prev_e !== 1'b1) begin
      rise_edge.push_back(edge_n);
      rise_db.push_back(bus.lcd_db);
    end
    prev_e = bus.lcd_e;
  endtask

  // Drive inputs at the negedge, clock one edge, update the model, check at the next negedge.
  task automatic step(input logic v, input logic rs, input logic [7:0] d);
    bit acc;
    bus.in_valid = v;
    bus.in_rs    = rs;
    bus.in_data  = d;
    acc = m_ready() && v;
    @(posedge clk);
    edge_n++;
    if (acc) begin
      m_active = 1'b1;
      m_d      = 0;
      m_rs     = rs;
      m_db     = d;
      m_w      = (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? LW : W;
      acc_edge = edge_n;
    end else if (m_active) begin
      m_d++;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 8'($urandom));
  endtask

  initial begin
    int idx;
    bus.in_valid = 1'b0;
    bus.in_rs    = 1'b0;
    bus.in_data  = 8'h00;
    m_active = 1'b0; m_d = 0; m_w = W; m_rs = 1'b0; m_db = 8'h00;
    edge_n = 0; acc_edge = 0; done_lat = -1; prev_e = 1'b0;

    // Reset held, then released with in_valid low.
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    idle(5);
    chk("no_done_after_reset", 32'(done_lat), 32'(-1));

    // Single instruction 0x38: done 19 edges after accept.
    done_lat = -1;
    step(1'b1, 1'b0, 8'h38);
    idle(24);
    chk("latency_cmd_38", 32'(done_lat), 32'(19));

    // Clear: long wait.
    done_lat = -1;
    step(1'b1, 1'b0, 8'h01);
    idle(44);
    chk("latency_clear", 32'(done_lat), 32'(39));

    // Data byte 0x01 is not a clear.
    done_lat = -1;
    step(1'b1, 1'b1, 8'h01);
    idle(24);
    chk("latency_data_01", 32'(done_lat), 32'(19));

    // Return home 0x02: long wait.
    done_lat = -1;
    step(1'b1, 1'b0, 8'h02);
    idle(44);
    chk("latency_home", 32'(done_lat), 32'(39));

    // in_valid held high across a four-byte stream, garbage on inputs while busy.
    rise_edge.delete();
    rise_db.delete();
    idx = 0;
    for (int c = 0; c < 120; c++) begin
      if (idx < 4) begin
        if (m_ready()) step(1'b1, 1'b0, stream[idx]);
        else           step(1'b1, 1'($urandom), 8'($urandom));
        if (acc_edge == edge_n) idx++;
      end else begin
        step(1'b0, 1'($urandom), 8'($urandom));
      end
    end
    chk("stream_pulses", 32'(rise_edge.size()), 32'(4));
    for (int i = 0; i < 4 && i < rise_db.size(); i++)
      chk("stream_db", 32'(rise_db[i]), 32'(stream[i]));
    for (int i = 0; i < 3 && i + 1 < rise_edge.size(); i++)
      chk("stream_gap", 32'(rise_edge[i+1] - rise_edge[i]), 32'(S + P + H + W + 1));

    // Reset asserted in the middle of the E pulse.
    step(1'b1, 1'b0, 8'h0C);
    for (int c = 0; c < 10 && !(m_active && m_d == S + 1); c++) idle(1);
    chk("e_high_before_abort", 32'(bus.lcd_e), 32'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("abort_e",     32'(bus.lcd_e),    32'(1'b0));
    chk("abort_ready", 32'(bus.in_ready), 32'(1'b1));
    chk("abort_busy",  32'(bus.busy),     32'(1'b0));
    chk("abort_db",    32'(bus.lcd_db),   32'(8'h00));
    chk("abort_rs",    32'(bus.lcd_rs),   32'(1'b0));
    chk("abort_done",  32'(bus.done),     32'(1'b0));
    m_active = 1'b0; m_rs = 1'b0; m_db = 8'h00; prev_e = 1'b0;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    done_lat = -1;
    idle(5);
    chk("no_done_after_abort", 32'(done_lat), 32'(-1));
    rise_edge.delete();
    rise_db.delete();
    step(1'b1, 1'b1, 8'h48);
    idle(24);
    chk("post_abort_latency", 32'(done_lat), 32'(19));
    chk("post_abort_pulses",  32'(rise_edge.size()), 32'(1));

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      logic       v;
      logic       rs;
      logic [7:0] d;
      v  = ($urandom_range(0, 2) == 0);
      rs = 1'($urandom);
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      step(v, rs, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
